// File: rtl/jesd204b_pkg.sv
// Shared JESD204B transport-layer definitions for the TX and RX paths.
// Mode codes and the lane-padded converter count.
package jesd204b_pkg;

    localparam logic [1:0] MODE_NORMAL  = 2'd0;
    localparam logic [1:0] MODE_RAMP    = 2'd1;
    localparam logic [1:0] MODE_CHECKER = 2'd2;

    // Converter count rounded up to a whole number of lane groups.
    function automatic int padded_conv(input int m, input int l);
        return ((m + l - 1) / l) * l;
    endfunction

endpackage

// File: rtl/jesd204b_tpl_tx_pack.sv
// Maps per-converter samples and control bits onto MSB-aligned frame words.
// Words beyond the real converters are dummy words and stay zero.
module jesd204b_tpl_tx_pack
    import jesd204b_pkg::*;
#(
    parameter int LANES       = 4,
    parameter int CONVERTERS  = 8,
    parameter int RESOLUTION  = 11,
    parameter int CONTROL     = 2,
    parameter int SAMPLE_SIZE = 16,
    parameter int SAMPLES     = 1,
    localparam int CP = padded_conv(CONVERTERS, LANES),
    localparam int TW = SAMPLES * SAMPLE_SIZE * CP,
    localparam int DW = SAMPLES * CONVERTERS * RESOLUTION,
    localparam int CW = SAMPLES * CONVERTERS * CONTROL
) (
    input  logic [DW-1:0] samples,
    input  logic [CW-1:0] ctrl,
    output logic [TW-1:0] frame
);

    localparam int SS = SAMPLE_SIZE;
    localparam int R  = RESOLUTION;
    localparam int CS = CONTROL;

    for (genvar n = 0; n < SAMPLES * CP; n++) begin : g_word
        if (n < SAMPLES * CONVERTERS) begin : g_live
            if (CS > 0) begin : g_ctrl
                assign frame[n*SS +: SS] =
                    (SS'(samples[n*R +: R]) << (SS - R)) |
                    (SS'(ctrl[n*CS +: CS]) << (SS - R - CS));
            end else begin : g_noctrl
                assign frame[n*SS +: SS] =
                    SS'(samples[n*R +: R]) << (SS - R);
            end
        end else begin : g_dummy
            assign frame[n*SS +: SS] = '0;
        end
    end

endmodule

// File: rtl/jesd204b_tpl_tx.sv
// JESD204B TX transport layer: 2-entry skid FIFO, test-pattern mux and
// frame output register feeding the data link layer.
module jesd204b_tpl_tx
    import jesd204b_pkg::*;
#(
    parameter int LANES       = 4,
    parameter int CONVERTERS  = 8,
    parameter int RESOLUTION  = 11,
    parameter int CONTROL     = 2,
    parameter int SAMPLE_SIZE = 16,
    parameter int SAMPLES     = 1,
    localparam int CP = padded_conv(CONVERTERS, LANES),
    localparam int TW = SAMPLES * SAMPLE_SIZE * CP,
    localparam int DW = SAMPLES * CONVERTERS * RESOLUTION,
    localparam int CW = SAMPLES * CONVERTERS * CONTROL
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          en,
    input  logic [1:0]    mode,
    input  logic [DW-1:0] tx_datain,
    input  logic [CW-1:0] tx_ctrlin,
    input  logic          tx_valid,
    output logic          tx_ready,
    output logic [TW-1:0] tx_dataout,
    output logic          tx_out_valid,
    input  logic          link_ready
);

    localparam int R = RESOLUTION;
    localparam logic [R-1:0] CHK = R'(64'h5555_5555_5555_5555);

    logic [DW-1:0] fifo_d [2];
    logic [CW-1:0] fifo_c [2];
    logic          rd_ptr;
    logic          wr_ptr;
    logic [1:0]    count;
    logic [R-1:0]  cnt;
    logic          phase;

    logic          test_mode;
    logic          empty;
    logic          full;
    logic          push;
    logic          load;
    logic          direct;
    logic          pop;
    logic          wr;
    logic          frame_ok;
    logic [DW-1:0] sel_d;
    logic [CW-1:0] sel_c;
    logic [TW-1:0] packed_frame;

    assign test_mode = (mode == MODE_RAMP) || (mode == MODE_CHECKER);
    assign empty     = (count == 2'd0);
    assign full      = (count == 2'd2);
    assign tx_ready  = !reset && !full && !test_mode;

    assign push   = en && tx_valid && tx_ready;
    assign load   = en && (!tx_out_valid || link_ready);
    // An empty FIFO lets a new frame go straight to the output register.
    assign direct = load && !test_mode && empty && push;
    assign pop    = load && !test_mode && !empty;
    assign wr     = push && !direct;

    always_comb begin
        sel_d    = fifo_d[rd_ptr];
        sel_c    = fifo_c[rd_ptr];
        frame_ok = !empty;
        unique case (1'b1)
            (mode == MODE_RAMP): begin
                sel_c    = '0;
                frame_ok = 1'b1;
                for (int n = 0; n < SAMPLES * CONVERTERS; n++) begin
                    sel_d[n*R +: R] = cnt + R'(n % SAMPLES);
                end
            end
            (mode == MODE_CHECKER): begin
                sel_c    = '0;
                frame_ok = 1'b1;
                for (int n = 0; n < SAMPLES * CONVERTERS; n++) begin
                    sel_d[n*R +: R] = phase ? ~CHK : CHK;
                end
            end
            default: begin
                if (empty) begin
                    sel_d    = tx_datain;
                    sel_c    = tx_ctrlin;
                    frame_ok = push;
                end
            end
        endcase
    end

    jesd204b_tpl_tx_pack #(
        .LANES       (LANES),
        .CONVERTERS  (CONVERTERS),
        .RESOLUTION  (RESOLUTION),
        .CONTROL     (CONTROL),
        .SAMPLE_SIZE (SAMPLE_SIZE),
        .SAMPLES     (SAMPLES)
    ) u_pack (
        .samples (sel_d),
        .ctrl    (sel_c),
        .frame   (packed_frame)
    );

    always_ff @(posedge clk) begin
        if (wr) begin
            fifo_d[wr_ptr] <= tx_datain;
            fifo_c[wr_ptr] <= tx_ctrlin;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rd_ptr       <= 1'b0;
            wr_ptr       <= 1'b0;
            count        <= 2'd0;
            cnt          <= '0;
            phase        <= 1'b0;
            tx_dataout   <= '0;
            tx_out_valid <= 1'b0;
        end else begin
            count <= count + 2'(wr) - 2'(pop);
            if (wr) begin
                wr_ptr <= ~wr_ptr;
            end
            if (pop) begin
                rd_ptr <= ~rd_ptr;
            end
            if (load) begin
                tx_out_valid <= frame_ok;
                if (frame_ok) begin
                    tx_dataout <= packed_frame;
                end
                if (mode == MODE_RAMP) begin
                    cnt <= cnt + R'(SAMPLES);
                end
                if (mode == MODE_CHECKER) begin
                    phase <= ~phase;
                end
            end
        end
    end

endmodule

// File: tb/tb_jesd204b_tpl_tx.sv
// Directed bench for jesd204b_tpl_tx: default build plus a 6-converter
// build that exercises lane padding.
module tb_jesd204b_tpl_tx;

    logic         clk = 1'b0;
    logic         reset;
    logic         en;
    logic [1:0]   mode;
    logic [87:0]  datain;
    logic [15:0]  ctrlin;
    logic         valid;
    logic         ready;
    logic [127:0] dout;
    logic         ovalid;
    logic         lrdy;

    logic [1:0]   p_mode;
    logic [65:0]  p_din;
    logic [11:0]  p_ctrl;
    logic         p_valid;
    logic         p_ready;
    logic [127:0] p_dout;
    logic         p_ovalid;
    logic         p_lrdy;

    int total  = 0;
    int passed = 0;
    int failed = 0;

    always #5 clk = ~clk;

    jesd204b_tpl_tx dut (
        .clk          (clk),
        .reset        (reset),
        .en           (en),
        .mode         (mode),
        .tx_datain    (datain),
        .tx_ctrlin    (ctrlin),
        .tx_valid     (valid),
        .tx_ready     (ready),
        .tx_dataout   (dout),
        .tx_out_valid (ovalid),
        .link_ready   (lrdy)
    );

    jesd204b_tpl_tx #(.CONVERTERS(6)) dut_pad (
        .clk          (clk),
        .reset        (reset),
        .en           (en),
        .mode         (p_mode),
        .tx_datain    (p_din),
        .tx_ctrlin    (p_ctrl),
        .tx_valid     (p_valid),
        .tx_ready     (p_ready),
        .tx_dataout   (p_dout),
        .tx_out_valid (p_ovalid),
        .link_ready   (p_lrdy)
    );

    task automatic chk(input string tag, input logic [127:0] obs,
                       input logic [127:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            failed++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [15:0] w;
        reset   = 1'b1;
        en      = 1'b1;
        mode    = 2'd0;
        datain  = '0;
        ctrlin  = '0;
        valid   = 1'b0;
        lrdy    = 1'b1;
        p_mode  = 2'd0;
        p_din   = '0;
        p_ctrl  = '0;
        p_valid = 1'b0;
        p_lrdy  = 1'b1;

        // reset state
        step();
        step();
        chk("rst_ready", 128'(ready), 128'(1'b0));
        chk("rst_ovalid", 128'(ovalid), 128'(1'b0));
        chk("rst_dout", dout, 128'h0);
        reset = 1'b0;
        #1;
        chk("rel_ready", 128'(ready), 128'(1'b1));
        chk("rel_pready", 128'(p_ready), 128'(1'b1));

        // normal packing, one-cycle latency
        datain = {8{11'h71B}};
        valid  = 1'b1;
        step();
        valid = 1'b0;
        chk("n_ovalid", 128'(ovalid), 128'(1'b1));
        chk("n_dout", dout, {8{16'hE360}});
        chk("n_lane0", 128'(dout[31:0]), 128'(32'hE360E360));
        chk("n_lane3", 128'(dout[127:96]), 128'(32'hE360E360));
        step();
        chk("n_drain_ov", 128'(ovalid), 128'(1'b0));
        chk("n_hold", dout, {8{16'hE360}});

        // control bits
        datain = '0;
        datain[10:0]  = 11'h6BB;
        datain[21:11] = 11'h7FF;
        ctrlin = 16'h0007;
        valid  = 1'b1;
        step();
        valid  = 1'b0;
        ctrlin = '0;
        chk("c_word0", 128'(dout[15:0]), 128'(16'hD778));
        chk("c_word1", 128'(dout[31:16]), 128'(16'hFFE8));
        chk("c_full", dout, {96'h0, 16'hFFE8, 16'hD778});
        step();

        // backpressure
        lrdy   = 1'b0;
        datain = {8{11'h001}};
        valid  = 1'b1;
        step();
        datain = {8{11'h002}};
        step();
        datain = {8{11'h003}};
        step();
        chk("bp_ready", 128'(ready), 128'(1'b0));
        chk("bp_a", dout, {8{16'h0020}});
        datain = {8{11'h004}};
        step();
        chk("bp_refuse", dout, {8{16'h0020}});
        chk("bp_ov", 128'(ovalid), 128'(1'b1));
        valid = 1'b0;
        lrdy  = 1'b1;
        step();
        chk("bp_b", dout, {8{16'h0040}});
        chk("bp_ready2", 128'(ready), 128'(1'b1));
        step();
        chk("bp_c", dout, {8{16'h0060}});
        chk("bp_c_ov", 128'(ovalid), 128'(1'b1));
        step();
        chk("bp_end_ov", 128'(ovalid), 128'(1'b0));
        chk("bp_end_hold", dout, {8{16'h0060}});

        // enable low holds everything
        en     = 1'b0;
        valid  = 1'b1;
        datain = {8{11'h005}};
        step();
        step();
        chk("en_ov", 128'(ovalid), 128'(1'b0));
        chk("en_dout", dout, {8{16'h0060}});
        en = 1'b1;
        step();
        valid = 1'b0;
        chk("en_go", dout, {8{16'h00A0}});

        // padding: 6 converters over 4 lanes
        p_din   = {6{11'h7FF}};
        p_ctrl  = {6{2'b01}};
        p_valid = 1'b1;
        step();
        p_valid = 1'b0;
        chk("pad_ov", 128'(p_ovalid), 128'(1'b1));
        chk("pad_dout", p_dout, {32'h0, {6{16'hFFE8}}});
        chk("pad_lane3", 128'(p_dout[127:96]), 128'h0);

        // ramp
        mode = 2'd1;
        #1;
        chk("ramp_ready", 128'(ready), 128'(1'b0));
        for (int i = 0; i < 2050; i++) begin
            step();
            w = 16'((i % 2048) << 5);
            chk("ramp", dout, {8{w}});
        end
        chk("ramp_ov", 128'(ovalid), 128'(1'b1));

        // checkerboard, then ramp resumes its count
        mode = 2'd2;
        step();
        chk("chk0", dout, {8{16'hAAA0}});
        step();
        chk("chk1", dout, {8{16'h5540}});
        mode = 2'd1;
        step();
        chk("ramp_resume", dout, {8{16'h0040}});

        // reset while stalled with two frames queued
        mode   = 2'd0;
        lrdy   = 1'b0;
        valid  = 1'b1;
        datain = {8{11'h006}};
        step();
        datain = {8{11'h007}};
        step();
        valid = 1'b0;
        chk("r6_ready", 128'(ready), 128'(1'b0));
        chk("r6_stall", dout, {8{16'h0040}});
        reset = 1'b1;
        #1;
        chk("r6_ov", 128'(ovalid), 128'(1'b0));
        chk("r6_dout", dout, 128'h0);
        chk("r6_rdy", 128'(ready), 128'(1'b0));
        step();
        reset = 1'b0;
        lrdy  = 1'b1;
        #1;
        chk("r6_rel", 128'(ready), 128'(1'b1));
        step();
        chk("r6_empty", 128'(ovalid), 128'(1'b0));
        datain = {8{11'h008}};
        valid  = 1'b1;
        step();
        valid = 1'b0;
        chk("r6_after", dout, {8{16'h0100}});

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
